// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned RET_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_HALT   = 7'h7f;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_HALT   = 4'd8
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [1:0] aluop;
    logic       alusrc;
  } dec_t;

  // Map a raw opcode to its instruction class; CL_NONE marks unsupported opcodes.
  function automatic iclass_e op_class(input logic [OP_W-1:0] op);
    iclass_e cls;
    case (op)
      OP_RTYPE:  cls = CL_R;
      OP_ITYPE:  cls = CL_I;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_HALT:   cls = CL_HALT;
      default:   cls = CL_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory handshake and control bundle.
interface multicycle_ctrl_if import riscv_ctrl_pkg::*; ();

  logic [OP_W-1:0]  opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             branch_taken;

  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic [1:0]       aluop;
  logic             alusrc;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             wb_link;
  logic             reg_write;
  logic             illegal;
  logic             halted;
  logic [RET_W-1:0] retired;

  modport slave (
    input  opcode, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_write, pc_write, pc_sel, aluop, alusrc,
           mem_read, mem_write, mem_to_reg, wb_link, reg_write,
           illegal, halted, retired
  );

  modport master (
    output opcode, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_write, pc_write, pc_sel, aluop, alusrc,
           mem_read, mem_write, mem_to_reg, wb_link, reg_write,
           illegal, halted, retired
  );

endinterface

// File: rtl/main_decoder.sv
// Combinational main decoder: latched opcode -> class, ALU op and operand select.
module main_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  output dec_t            o_dec_c
);

  iclass_e w_cls;

  assign w_cls = op_class(i_op);

  // ALU control per instruction class (only consumed in EXEC).
  always_comb begin
    o_dec_c        = '0;
    o_dec_c.cls    = w_cls;
    case (w_cls)
      CL_R:      begin o_dec_c.aluop = ALU_R;   o_dec_c.alusrc = 1'b0; end
      CL_I:      begin o_dec_c.aluop = ALU_I;   o_dec_c.alusrc = 1'b1; end
      CL_LOAD,
      CL_STORE:  begin o_dec_c.aluop = ALU_ADD; o_dec_c.alusrc = 1'b1; end
      CL_BRANCH,
      CL_JAL:    begin o_dec_c.aluop = ALU_BR;  o_dec_c.alusrc = 1'b0; end
      CL_JALR:   begin o_dec_c.aluop = ALU_ADD; o_dec_c.alusrc = 1'b1; end
      default:   begin o_dec_c.aluop = ALU_ADD; o_dec_c.alusrc = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with retired-instruction counter.
// Control strobes are combinational (Mealy on the ready inputs) so a memory
// handshake completes in the same cycle the ready arrives.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.slave io_bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [OP_W-1:0]  r_op;
  logic [RET_W-1:0] r_retired;
  wire  [RET_W-1:0] w_retired_nxt;
  logic             w_retire;
  dec_t             w_dec;
  iclass_e          w_raw_cls;

  main_decoder u_main_decoder (
    .i_op    (r_op),
    .o_dec_c (w_dec)
  );

  assign w_raw_cls     = op_class(io_bus.opcode);
  assign w_retired_nxt = r_retired + RET_W'(w_retire);
  assign io_bus.retired = r_retired;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Capture the opcode while in DECODE; EXEC/MEM/WB work from this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_op <= '0;
    else if (r_state == S_DECODE)  r_op <= io_bus.opcode;
  end

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_retired <= '0;
    else        r_retired <= w_retired_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt       = r_state;
    w_retire          = 1'b0;
    io_bus.imem_req   = 1'b0;
    io_bus.ir_write   = 1'b0;
    io_bus.pc_write   = 1'b0;
    io_bus.pc_sel     = PC_PLUS4;
    io_bus.aluop      = ALU_ADD;
    io_bus.alusrc     = 1'b0;
    io_bus.mem_read   = 1'b0;
    io_bus.mem_write  = 1'b0;
    io_bus.mem_to_reg = 1'b0;
    io_bus.wb_link    = 1'b0;
    io_bus.reg_write  = 1'b0;
    io_bus.illegal    = 1'b0;
    io_bus.halted     = 1'b0;

    case (r_state)
      S_FETCH: begin
        io_bus.imem_req = 1'b1;
        if (io_bus.imem_ready) begin
          io_bus.ir_write = 1'b1;
          io_bus.pc_write = 1'b1;
          io_bus.pc_sel   = PC_PLUS4;
          w_state_nxt     = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_raw_cls)
          CL_HALT: w_state_nxt = S_HALT;
          CL_NONE: begin
            io_bus.illegal = 1'b1;
            w_state_nxt    = S_FETCH;
          end
          default: w_state_nxt = S_EXEC;
        endcase
      end

      S_EXEC: begin
        io_bus.aluop  = w_dec.aluop;
        io_bus.alusrc = w_dec.alusrc;
        case (w_dec.cls)
          CL_R, CL_I:          w_state_nxt = S_WB;
          CL_LOAD, CL_STORE:   w_state_nxt = S_MEM;
          CL_BRANCH: begin
            io_bus.pc_write = io_bus.branch_taken;
            io_bus.pc_sel   = PC_IMM;
            w_retire        = 1'b1;
            w_state_nxt     = S_FETCH;
          end
          CL_JAL: begin
            io_bus.pc_write = 1'b1;
            io_bus.pc_sel   = PC_IMM;
            w_state_nxt     = S_WB;
          end
          CL_JALR: begin
            io_bus.pc_write = 1'b1;
            io_bus.pc_sel   = PC_JALR;
            w_state_nxt     = S_WB;
          end
          default:             w_state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        io_bus.aluop  = ALU_ADD;
        io_bus.alusrc = 1'b1;
        case (w_dec.cls)
          CL_LOAD: begin
            io_bus.mem_read = 1'b1;
            if (io_bus.dmem_ready) w_state_nxt = S_WB;
          end
          CL_STORE: begin
            io_bus.mem_write = 1'b1;
            if (io_bus.dmem_ready) begin
              w_retire    = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end

      S_WB: begin
        io_bus.reg_write  = 1'b1;
        io_bus.mem_to_reg = (w_dec.cls == CL_LOAD);
        io_bus.wb_link    = (w_dec.cls == CL_JAL) || (w_dec.cls == CL_JALR);
        w_retire          = 1'b1;
        w_state_nxt       = S_FETCH;
      end

      S_HALT: begin
        io_bus.halted = 1'b1;
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, random instruction
// stream against a per-instruction behavioural model, and reset/halt/wrap cases.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Expected per-instruction behaviour, observed after the fetch handshake
  // until the controller is back asking for the next instruction.
  typedef struct {
    logic [6:0] op;
    int         iw;     // imem wait cycles before ready
    int         mw;     // dmem wait cycles before ready
    logic       bt;     // branch_taken
    int         cyc;    // cycles between fetch handshake and next fetch
    int         ret;    // retired increment
    int         regw;   // reg_write cycles
    int         rd;     // mem_read cycles
    int         wr;     // mem_write cycles
    int         pcw;    // pc_write cycles
    logic [1:0] pcsel;  // pc_sel when pc_write
    int         ill;    // illegal cycles
    int         m2r;    // mem_to_reg cycles
    int         link;   // wb_link cycles
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: latency and side effects of one instruction from the ISA-level rules.
  function automatic vec_t model(input logic [6:0] op, input int iw, input int mw, input logic bt);
    vec_t v;
    v = '{op, iw, mw, bt, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0};
    case (op)
      7'b0110011, 7'b0010011: begin v.cyc = 3; v.ret = 1; v.regw = 1; end
      7'b0000011: begin v.cyc = 4 + mw; v.ret = 1; v.regw = 1; v.rd = mw + 1; v.m2r = 1; end
      7'b0100011: begin v.cyc = 3 + mw; v.ret = 1; v.wr = mw + 1; end
      7'b1100011: begin v.cyc = 2; v.ret = 1; v.pcw = bt ? 1 : 0; v.pcsel = 2'd1; end
      7'b1101111: begin v.cyc = 3; v.ret = 1; v.regw = 1; v.pcw = 1; v.pcsel = 2'd1; v.link = 1; end
      7'b1100111: begin v.cyc = 3; v.ret = 1; v.regw = 1; v.pcw = 1; v.pcsel = 2'd2; v.link = 1; end
      default:    begin v.cyc = 1; v.ill = 1; end
    endcase
    return v;
  endfunction

  // Fetch, execute and observe one instruction, then compare with e.
  task automatic run_instr(input vec_t e);
    logic [31:0] ret0;
    int cyc, regw, rd, wr, pcw, ill, m2r, link, mseen;
    logic [1:0] pcsel;
    bit done;
    cyc = 0; regw = 0; rd = 0; wr = 0; pcw = 0; ill = 0; m2r = 0; link = 0; mseen = 0;
    pcsel = 2'd0; done = 1'b0;
    @(posedge clk); #1;
    bus.opcode = e.op; bus.branch_taken = e.bt; bus.dmem_ready = 1'b0; bus.imem_ready = 1'b0;
    for (int i = 0; i < e.iw; i++) begin
      @(negedge clk);
      chk("fetch_wait_ir_write", 32'(bus.ir_write), 0);
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b1;
    @(negedge clk);
    ret0 = bus.retired;
    chk("fetch_imem_req", 32'(bus.imem_req), 1);
    chk("fetch_ir_write", 32'(bus.ir_write), 1);
    chk("fetch_pc_write", 32'(bus.pc_write), 1);
    chk("fetch_pc_sel", 32'(bus.pc_sel), 0);
    @(posedge clk); #1;
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      bus.dmem_ready = (mseen == e.mw);
      @(negedge clk);
      if (bus.imem_req) done = 1'b1;
      else begin
        cyc++;
        regw += int'(bus.reg_write);
        rd   += int'(bus.mem_read);
        wr   += int'(bus.mem_write);
        ill  += int'(bus.illegal);
        m2r  += int'(bus.mem_to_reg);
        link += int'(bus.wb_link);
        if (bus.pc_write) begin pcw++; pcsel = bus.pc_sel; end
        if (bus.mem_read || bus.mem_write) mseen++;
        @(posedge clk); #1;
        if (cyc == 1) bus.opcode = 7'($urandom);
      end
    end
    bus.dmem_ready = 1'b0;
    chk("body_completed", 32'(done), 1);
    chk("body_cycles", cyc, e.cyc);
    chk("retired_delta", bus.retired - ret0, e.ret);
    chk("reg_write_cycles", regw, e.regw);
    chk("mem_read_cycles", rd, e.rd);
    chk("mem_write_cycles", wr, e.wr);
    chk("pc_write_cycles", pcw, e.pcw);
    if (e.pcw > 0) chk("pc_sel", 32'(pcsel), 32'(e.pcsel));
    chk("illegal_cycles", ill, e.ill);
    chk("mem_to_reg_cycles", m2r, e.m2r);
    chk("wb_link_cycles", link, e.link);
  endtask

  vec_t        tbl [11];
  logic [6:0]  legal_ops [7];
  logic [6:0]  rop;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              op          iw mw bt    cyc ret regw rd wr pcw pcsel ill m2r link
    tbl[0]  = '{7'b0110011, 0, 0, 1'b0, 3, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0};  // add
    tbl[1]  = '{7'b0000011, 0, 3, 1'b0, 7, 1, 1, 4, 0, 0, 2'd0, 0, 1, 0};  // lw, 3 waits
    tbl[2]  = '{7'b1100011, 0, 0, 1'b1, 2, 1, 0, 0, 0, 1, 2'd1, 0, 0, 0};  // beq taken
    tbl[3]  = '{7'b1100011, 1, 0, 1'b0, 2, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0};  // beq not taken
    tbl[4]  = '{7'b1111011, 0, 0, 1'b0, 1, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0};  // illegal
    tbl[5]  = '{7'b0100011, 2, 0, 1'b0, 3, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0};  // sw
    tbl[6]  = '{7'b1101111, 0, 0, 1'b0, 3, 1, 1, 0, 0, 1, 2'd1, 0, 0, 1};  // jal
    tbl[7]  = '{7'b1100111, 1, 0, 1'b1, 3, 1, 1, 0, 0, 1, 2'd2, 0, 0, 1};  // jalr
    tbl[8]  = '{7'b0010011, 0, 2, 1'b1, 3, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0};  // addi
    tbl[9]  = '{7'b0100011, 0, 2, 1'b0, 5, 1, 0, 0, 3, 0, 2'd0, 0, 0, 0};  // sw, 2 waits
    tbl[10] = '{7'b0000011, 3, 0, 1'b0, 4, 1, 1, 1, 0, 0, 2'd0, 0, 1, 0};  // lw, no wait
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b1100111};

    bus.opcode = 7'd0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b0;

    // Reset state.
    #12;
    chk("rst_imem_req", 32'(bus.imem_req), 1);
    chk("rst_ir_write", 32'(bus.ir_write), 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_retired", bus.retired, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_imem_req", 32'(bus.imem_req), 1);

    // Directed table.
    for (int i = 0; i < 11; i++) run_instr(tbl[i]);
    chk("retired_after_table", bus.retired, 10);

    // Random instruction stream against the model.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 7'($urandom);
        if (rop == 7'h7f || op_class(rop) != CL_NONE) rop = 7'b1111011;
      end else begin
        rop = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(model(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom)));
    end

    // Counter wrap: preload all-ones, then one add.
    @(posedge clk); #1;
    force dut.w_retired_nxt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.w_retired_nxt;
    @(negedge clk);
    chk("retired_preload", bus.retired, 32'hFFFF_FFFF);
    run_instr(model(7'b0110011, 0, 0, 1'b0));
    chk("retired_wrap", bus.retired, 0);
    run_instr(model(7'b0110011, 0, 0, 1'b0));
    chk("retired_after_wrap", bus.retired, 1);

    // Reset in the middle of a stalled load.
    @(posedge clk); #1;
    bus.opcode = 7'b0000011; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    @(posedge clk); #1; bus.imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mem_read_before_rst", 32'(bus.mem_read), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mem_read_dropped", 32'(bus.mem_read), 0);
    chk("rst_mid_imem_req", 32'(bus.imem_req), 1);
    chk("rst_mid_retired", bus.retired, 0);
    @(negedge clk); rst_n = 1'b1;
    run_instr(model(7'b0100011, 1, 1, 1'b0));
    chk("retired_after_mid_rst", bus.retired, 1);

    // HALT: stays put regardless of imem_ready, until reset.
    @(posedge clk); #1;
    bus.opcode = 7'h7f; bus.imem_ready = 1'b1;
    @(posedge clk); #1; bus.imem_ready = 1'b0;
    @(negedge clk);
    chk("halt_decode_illegal", 32'(bus.illegal), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ready = 1'(i);
      bus.dmem_ready = 1'(i >> 1);
      @(negedge clk);
      chk("halt_halted", 32'(bus.halted), 1);
      chk("halt_imem_req", 32'(bus.imem_req), 0);
      chk("halt_ir_write", 32'(bus.ir_write), 0);
      @(posedge clk); #1;
    end
    chk("halt_retired_kept", bus.retired, 1);
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(bus.halted), 0);
    chk("halt_rst_imem_req", 32'(bus.imem_req), 1);
    chk("halt_rst_retired", bus.retired, 0);
    @(negedge clk); rst_n = 1'b1;
    run_instr(model(7'b0010011, 0, 0, 1'b0));
    chk("retired_after_halt_rst", bus.retired, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
